fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_pkg.sv | 23 ++
 rtl/pix_fifo.sv | 64 ++++++
 rtl/fb_writer.sv | 141 ++++++++++++++
 tb/tb_fb_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer writer: FSM states, address
// constants and the pixel packing function.
package fb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_e;

  localparam int          FB_ADDR_W    = 16;
  localparam logic [15:0] FB_LAST_ADDR = 16'hFFFF;
  localparam int          FB_ENTRY_W   = 24;

  // fmt 0: RGB332, fmt 1: grey taken from the red channel.
  function automatic logic [7:0] pack_pixel(input int fmt, input logic [7:0] r,
                                            input logic [7:0] g, input logic [7:0] b);
    if (fmt == 1) begin
      return r;
    end
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Circular pixel FIFO with registered occupancy and a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module pix_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FB_ENTRY_W,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             ovf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !do_push) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: detects new pixel addresses from the draw stage, queues
// packed pixels and streams them to the framebuffer with a ready handshake.
module fb_writer
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FMT   = 0
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic [7:0]             X,
  input  logic [7:0]             Y,
  input  logic [7:0]             R,
  input  logic [7:0]             G,
  input  logic [7:0]             B,
  input  logic                   MEM_READY,
  output logic                   MEM_WE,
  output logic [FB_ADDR_W-1:0]   MEM_ADDR,
  output logic [7:0]             MEM_DATA,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVF,
  output logic                   FRAME_DONE,
  output logic [7:0]             FRAME_CNT
);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic                  first_flag;
  logic [FB_ADDR_W-1:0]  last_addr;
  logic [FB_ADDR_W-1:0]  cur_addr;
  logic                  detect;
  logic [FB_ENTRY_W-1:0] push_entry;
  logic [FB_ENTRY_W-1:0] head;
  logic                  pop;
  logic                  we_next;
  logic                  completion;
  wr_state_e             state;
  wr_state_e             state_next;

  // Assertion is immediate; release reaches the core two edges later.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign cur_addr   = {Y, X};
  assign detect     = first_flag || (cur_addr != last_addr);
  assign push_entry = {cur_addr, pack_pixel(FMT, R, G, B)};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      first_flag <= 1'b1;
      last_addr  <= '0;
    end else begin
      first_flag <= 1'b0;
      if (detect) begin
        last_addr <= cur_addr;
      end
    end
  end

  pix_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FB_ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (rst_n),
    .push  (detect),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .level (LEVEL),
    .ovf   (OVF)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    we_next    = MEM_WE;
    case (state)
      IDLE: begin
        if (LEVEL != '0) begin
          pop        = 1'b1;
          we_next    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (MEM_READY) begin
          if (LEVEL != '0) begin
            pop = 1'b1;
          end else begin
            we_next    = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        we_next    = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign completion = (state == WRITE) && MEM_READY;

  // Popping always loads the head entry, so the bus only changes on a pop.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DATA   <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
    end else begin
      MEM_WE <= we_next;
      if (pop) begin
        MEM_ADDR <= head[FB_ENTRY_W-1:8];
        MEM_DATA <= head[7:0];
      end
      FRAME_DONE <= completion && (MEM_ADDR == FB_LAST_ADDR);
      if (completion && (MEM_ADDR == FB_LAST_ADDR)) begin
        FRAME_CNT <= FRAME_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: directed pixels push expected writes,
// a monitor process pops and compares on every completed write.
module tb_fb_writer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [7:0]  X = '0, Y = '0, R = '0, G = '0, B = '0;
  logic        MEM_READY = 1'b1;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic [$clog2(DEPTH):0] LEVEL;
  logic        OVF;
  logic        FRAME_DONE;
  logic [7:0]  FRAME_CNT;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  int nfd   = 0;
  int base;
  int fbase;
  logic [23:0] sbq[$];
  logic [23:0] ent;
  logic        prev_stall = 1'b0;
  logic        exp_fd = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;

  fb_writer #(.DEPTH(DEPTH), .FMT(0)) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .X          (X),
    .Y          (Y),
    .R          (R),
    .G          (G),
    .B          (B),
    .MEM_READY  (MEM_READY),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_DATA   (MEM_DATA),
    .LEVEL      (LEVEL),
    .OVF        (OVF),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_CNT  (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic set_px(input logic [15:0] a, input logic [23:0] c,
                        input logic [7:0] ed, input bit exp_wr);
    tick(1);
    {Y, X} = a;
    {R, G, B} = c;
    if (exp_wr) sbq.push_back({a, ed});
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (sbq.size() == 0 && !MEM_WE) break;
      tick(1);
    end
    chk("drain_queue", sbq.size(), 0);
    chk("drain_we", MEM_WE, 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLK);
        if (!NRST) begin
          prev_stall = 1'b0;
          exp_fd     = 1'b0;
        end else begin
          chk("frame_done", FRAME_DONE, exp_fd);
          if (FRAME_DONE) nfd++;
          if (prev_stall) begin
            chk("hold_we", MEM_WE, 1);
            chk("hold_addr", MEM_ADDR, prev_addr);
            chk("hold_data", MEM_DATA, prev_data);
          end
          exp_fd = 1'b0;
          if (MEM_WE && MEM_READY) begin
            nwr++;
            chk("write_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
              ent = sbq.pop_front();
              chk("mem_addr", MEM_ADDR, ent[23:8]);
              chk("mem_data", MEM_DATA, ent[7:0]);
            end
            exp_fd = (MEM_ADDR == 16'hFFFF);
          end
          prev_stall = MEM_WE && !MEM_READY;
          prev_addr  = MEM_ADDR;
          prev_data  = MEM_DATA;
        end
      end
    join_none

    // Reset values, with the first pixel already presented on the inputs
    {Y, X} = 16'h0102;
    {R, G, B} = 24'hFF00FF;
    tick(2);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_data", MEM_DATA, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_fd", FRAME_DONE, 0);
    chk("rst_fcnt", FRAME_CNT, 0);

    // Two synchroniser edges pass before the first detect edge
    sbq.push_back({16'h0102, 8'hE3});
    NRST = 1'b1;
    tick(3);
    chk("single_level", LEVEL, 1);
    chk("single_we_lo", MEM_WE, 0);
    tick(1);
    chk("single_we", MEM_WE, 1);
    chk("single_addr", MEM_ADDR, 16'h0102);
    chk("single_data", MEM_DATA, 8'hE3);
    drain();

    // Backpressure
    MEM_READY = 1'b0;
    set_px(16'h1010, 24'h204080, 8'h2A, 1);
    set_px(16'h1011, 24'hE0E0C0, 8'hFF, 1);
    set_px(16'h1012, 24'h00FF00, 8'h1C, 1);
    tick(8);
    chk("bp_level", LEVEL, 2);
    chk("bp_ovf", OVF, 0);
    chk("bp_we", MEM_WE, 1);
    chk("bp_addr", MEM_ADDR, 16'h1010);
    chk("bp_data", MEM_DATA, 8'h2A);
    base = nwr;
    MEM_READY = 1'b1;
    tick(3);
    chk("bp_b2b_count", nwr - base, 3);
    chk("bp_b2b_we", MEM_WE, 0);
    drain();

    // Latency and repeated address
    base = nwr;
    set_px(16'h0A0A, 24'h808080, 8'h92, 1);
    tick(1);
    chk("lat_level", LEVEL, 1);
    chk("lat_we_lo", MEM_WE, 0);
    tick(1);
    chk("lat_we", MEM_WE, 1);
    chk("lat_addr", MEM_ADDR, 16'h0A0A);
    tick(18);
    drain();
    chk("repeat_writes", nwr - base, 1);

    // Overflow
    MEM_READY = 1'b0;
    base = nwr;
    for (int i = 0; i < 6; i++) set_px(16'h2000 + 16'(i), 24'h60A040, 8'h75, i < 5);
    tick(2);
    chk("ovf_level", LEVEL, 4);
    chk("ovf_flag", OVF, 1);
    MEM_READY = 1'b1;
    drain();
    chk("ovf_writes", nwr - base, 5);
    chk("ovf_sticky", OVF, 1);

    // Frame wrap
    chk("frame_cnt0", FRAME_CNT, 0);
    fbase = nfd;
    set_px(16'hFFFE, 24'h000000, 8'h00, 1);
    set_px(16'hFFFF, 24'h000000, 8'h00, 1);
    set_px(16'h0000, 24'h000000, 8'h00, 1);
    drain();
    chk("frame_cnt1", FRAME_CNT, 1);
    chk("frame_pulses1", nfd - fbase, 1);
    for (int i = 0; i < 255; i++) begin
      set_px(16'hFFFF, 24'h000000, 8'h00, 1);
      set_px(16'h0000, 24'h000000, 8'h00, 1);
    end
    drain();
    chk("frame_cnt_wrap", FRAME_CNT, 0);
    chk("frame_pulses256", nfd - fbase, 256);

    // Reset in the middle of a stalled write
    MEM_READY = 1'b0;
    for (int i = 0; i < 4; i++) set_px(16'h4000 + 16'(i), 24'h000000, 8'h00, 0);
    tick(1);
    chk("mid_level", LEVEL, 3);
    chk("mid_we", MEM_WE, 1);
    #3;
    NRST = 1'b0;
    #1;
    chk("mid_rst_we", MEM_WE, 0);
    chk("mid_rst_level", LEVEL, 0);
    chk("mid_rst_addr", MEM_ADDR, 0);
    {Y, X} = 16'h5050;
    {R, G, B} = 24'hFFFFFF;
    sbq.push_back({16'h5050, 8'hFF});
    MEM_READY = 1'b1;
    base = nwr;
    tick(2);
    chk("mid_rst_ovf", OVF, 0);
    NRST = 1'b1;
    drain();
    chk("mid_first_writes", nwr - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
